// File: rtl/dma_engineer.sv
// Weight-fetch DMA responder: latches a layer request, issues in-order
// memory reads with bounded outstanding count, streams words back.
module dma_engineer #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_engineer_req,
    output logic                  dma_engineer_ack,
    input  logic [ADDR_WIDTH-1:0] dma_engineer_start_addr,
    input  logic [ADDR_WIDTH-1:0] dma_engineer_length,
    output logic                  dma_engineer_dout_en,
    output logic                  dma_engineer_dout_eop,
    output logic [DATA_WIDTH-1:0] dma_engineer_dout,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                  mem_rd_rdy,
    input  logic                  mem_rd_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy,
    output logic                  err_unexpected
);

    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] MAX_OUT = ADDR_WIDTH'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] issued;
    logic [ADDR_WIDTH-1:0] received;
    logic [ADDR_WIDTH-1:0] outstanding;
    logic                  issue;
    logic                  accept;
    logic                  last;
    logic                  start;

    // Responses only count while something is in flight; others are stray.
    assign outstanding = issued - received;
    assign issue       = mem_rd_en && mem_rd_rdy;
    assign accept      = mem_rd_valid && (outstanding != '0);
    assign last        = accept && ((received + ONE) == len_q);
    assign start       = (state == IDLE) && dma_engineer_req;
    assign mem_rd_addr = addr_q + issued;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (dma_engineer_req) state_nxt = ACK;
            ACK:  state_nxt = (len_q == '0) ? IDLE : RUN;
            RUN:  if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dma_engineer_ack = (state == ACK);
        busy             = (state == ACK) || (state == RUN);
        mem_rd_en        = (state == RUN)
                        && (issued < len_q)
                        && (outstanding < MAX_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q                <= '0;
            len_q                 <= '0;
            issued                <= '0;
            received              <= '0;
            dma_engineer_dout_en  <= 1'b0;
            dma_engineer_dout_eop <= 1'b0;
            dma_engineer_dout     <= '0;
            err_unexpected        <= 1'b0;
        end else begin
            if (start) begin
                addr_q   <= dma_engineer_start_addr;
                len_q    <= dma_engineer_length;
                issued   <= '0;
                received <= '0;
            end else begin
                if (issue)  issued   <= issued + ONE;
                if (accept) received <= received + ONE;
            end
            dma_engineer_dout_en  <= accept;
            dma_engineer_dout_eop <= last;
            if (accept) dma_engineer_dout <= mem_rd_data;
            if (mem_rd_valid && !accept) err_unexpected <= 1'b1;
        end
    end

endmodule
